// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the reaction-game sequencer and
// the LED/score stage.
//   state_t      : sequencer FSM states
//   led_idx_t    : 2-bit LED index (values 0..2 only)
//   LFSR_TAPS    : feedback mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   DEF_*        : default timing / seed parameters
//   pick_idx()   : LFSR value -> LED index, never repeating the previous one
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef logic [1:0] led_idx_t;

    localparam logic [7:0] LFSR_TAPS       = 8'b1011_1000;
    localparam int         DEF_STEP_CYCLES = 25_000_000;
    localparam int         DEF_ROUND_STEPS = 30;
    localparam logic [7:0] DEF_LFSR_SEED   = 8'hA5;

    // Candidate is the LFSR value mod 3; on a collision with the previous
    // target, step to the next index (mod 3) so targets always differ.
    function automatic led_idx_t pick_idx(input logic [7:0] v, input led_idx_t prev);
        led_idx_t cand;
        cand = 2'(v % 8'd3);
        if (cand == prev)
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        return cand;
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// game_lfsr: 8-bit Fibonacci LFSR plus mod-3 / no-repeat target mapping.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (LFSR <= LFSR_SEED)
//   advance  in  step the LFSR this cycle (tied high by the sequencer)
//   prev     in  previously issued target, used to avoid repeats
//   idx      out next target candidate, 0..2, differs from prev
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic [1:0] prev,
    output logic [1:0] idx
);

    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (lfsr == 8'd0)
            // Lock-up recovery: the all-zero state would never leave itself.
            lfsr <= LFSR_SEED;
        else if (advance)
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end

    always_comb begin
        idx = pick_idx(lfsr, prev);
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round sequencer for the reaction game. A rising edge on go
// starts a round of ROUND_STEPS target changes spaced STEP_CYCLES apart; the
// round ends with a one-cycle done pulse unless aborted or reset.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   go          in   player start request (level; only rising edges count)
//   abort       in   cancel the running round (level)
//   start       out  high exactly while a round is running
//   change      out  one-cycle pulse, new target on randNum
//   randNum     out  target LED index 0..2
//   steps_left  out  change pulses still to be issued this round
//   done        out  one-cycle pulse at normal round completion
module game_sequencer
    import game_pkg::*;
#(
    parameter int         STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int         ROUND_STEPS = DEF_ROUND_STEPS,
    parameter logic [7:0] LFSR_SEED   = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    output logic       start,
    output logic       change,
    output logic [1:0] randNum,
    output logic [5:0] steps_left,
    output logic       done
);

    localparam int             CW         = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(STEP_CYCLES - 1);
    localparam logic [5:0]     STEPS_INIT = 6'(ROUND_STEPS);

    state_t        state, state_n;
    logic          go_q;
    logic          go_edge;
    logic [CW-1:0] cnt, cnt_n;
    logic          start_n, change_n, done_n;
    logic [1:0]    rand_n;
    logic [5:0]    steps_n;
    logic [1:0]    cand_idx;

    game_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (1'b1),
        .prev    (randNum),
        .idx     (cand_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            // go_q starts high so a go held through reset is not an edge.
            go_q       <= 1'b1;
            cnt        <= '0;
            start      <= 1'b0;
            change     <= 1'b0;
            done       <= 1'b0;
            randNum    <= 2'd0;
            steps_left <= 6'd0;
        end else begin
            state      <= state_n;
            go_q       <= go;
            cnt        <= cnt_n;
            start      <= start_n;
            change     <= change_n;
            done       <= done_n;
            randNum    <= rand_n;
            steps_left <= steps_n;
        end
    end

    // All outputs are registered, so this block computes the values they
    // take in the cycle after the current edge. The first change of a round
    // is therefore issued on the LOAD -> RUN edge.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        start_n  = 1'b0;
        change_n = 1'b0;
        done_n   = 1'b0;
        rand_n   = randNum;
        steps_n  = steps_left;
        go_edge  = go & ~go_q;

        case (state)
            IDLE: begin
                if (go_edge) begin
                    state_n = LOAD;
                    steps_n = STEPS_INIT;
                    cnt_n   = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    state_n  = RUN;
                    start_n  = 1'b1;
                    change_n = 1'b1;
                    rand_n   = cand_idx;
                    steps_n  = steps_left - 6'd1;
                    cnt_n    = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort beats a coinciding final expiry: no done.
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (steps_left == 6'd0) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else begin
                        start_n  = 1'b1;
                        change_n = 1'b1;
                        rand_n   = cand_idx;
                        steps_n  = steps_left - 6'd1;
                    end
                end else begin
                    cnt_n   = cnt + CW'(1);
                    start_n = 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter STEP_CYCLES, default 25_000_000: clk cycles between consecutive change pulses (0.5 s at 50 MHz); minimum 2.
REQ-002 Parameter ROUND_STEPS, default 30: change pulses per round; range 1..63.
REQ-003 Parameter LFSR_SEED, default 8'hA5: LFSR reset value; nonzero.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 go  in  1  player start request; synchronous to clk; level.
REQ-007 abort  in  1  cancel the running round; synchronous, level.
REQ-008 start  out  1  high exactly while a round is running; feeds the LED/score stage's start.
REQ-009 change  out  1  one-cycle pulse; new target valid on randNum in the same cycle.
REQ-010 randNum  out  2  target LED index, only values 0..2.
REQ-011 steps_left  out  6  change pulses still to be issued in the current round.
REQ-012 done  out  1  one-cycle pulse at normal round completion.

Function
REQ-013 FSM states IDLE, LOAD, RUN and FIN; state, counters and all outputs registered.
REQ-014 go rising edge = go & ~go_q; go_q is a one-cycle delayed copy of go.
REQ-015 IDLE: start=0, change=0, done=0; go rising edge -> LOAD next cycle; go level without an edge is ignored.
REQ-016 LOAD lasts one cycle: steps_left <= ROUND_STEPS, step counter <= 0 -> RUN.
REQ-017 RUN: start=1; change pulses in the first RUN cycle, then every STEP_CYCLES cycles after that.
REQ-018 Each change decrements steps_left in the same clock edge that asserts change.
REQ-019 In RUN, step-counter expiry with steps_left==0 -> FIN, with no further change pulse.
REQ-020 Cycles with start=1 per completed round = ROUND_STEPS*STEP_CYCLES exactly.
REQ-021 FIN lasts one cycle: done=1, start=0 -> IDLE.
REQ-022 go edges during LOAD, RUN or FIN are ignored; no restart.
REQ-023 abort high in LOAD or RUN -> IDLE next cycle; start=0; no done; no change in that cycle.
REQ-024 abort and final step expiry in the same cycle: abort wins; done never asserts.
REQ-025 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle in every state, so the sequence depends on player timing.
REQ-026 LFSR never reaches all-zero; a zero state is forced to LFSR_SEED on the next cycle.
REQ-027 Candidate target = LFSR value mod 3.
REQ-028 If the candidate equals the previous randNum, issue (candidate+1) mod 3; consecutive targets always differ.
REQ-029 randNum changes only in cycles where change=1; otherwise it holds its value.
REQ-030 steps_left holds its value outside RUN/LOAD; it does not wrap below 0.

Reset
REQ-031 On rst=1 at a clk edge: state=IDLE, start=0, change=0, done=0, randNum=0, steps_left=0, step counter=0, go_q=1, LFSR=LFSR_SEED.
REQ-032 go_q=1 at reset, so a go held high through reset does not start a round.
REQ-033 rst during RUN ends the round immediately, with no done pulse.
REQ-034 rst has priority over abort, go and every counter event.

Structure
REQ-035 Shared package game_pkg holds: state enum (IDLE/LOAD/RUN/FIN), LFSR tap constant, default STEP_CYCLES/ROUND_STEPS/LFSR_SEED, and the 2-bit LED index type shared with the LED/score stage.
REQ-036 LFSR and mod-3/no-repeat mapping are in sub-module game_lfsr (ports clk, rst, advance-always, idx[1:0]).
REQ-037 FSM and counters are in game_sequencer.

Verification (STEP_CYCLES=4, ROUND_STEPS=3)
REQ-038 Normal round: go rises at cycle 10 -> LOAD at 11, change at 12/16/20, steps_left 2/1/0, start high 12..23, done at 24, start low at 24.
REQ-039 Abort: abort at cycle 17 mid-round -> start=0 at 18, IDLE, no done, no further change.
REQ-040 Collision: abort coincides with final expiry (cycle 23) -> IDLE, done stays 0.
REQ-041 Held go: go held high across reset release and the whole round -> exactly one round, only on a fresh rising edge; none from a held level.
REQ-042 Random sequence: 1000 rounds with random go timing -> randNum always in 0..2, never equal on consecutive changes, each value at 25-42%.
REQ-043 Reset mid-round: rst at cycle 14 -> all outputs at reset values at 15; LFSR = 8'hA5.
